hash_arbiter: RTL and testbench
===============================

# hash_arbiter

Shares one combinational `HashFunction` instance (16-bit linear hash) between the fetch-stage lookup path and the commit-stage update path of the branch predictor. Each cycle it grants at most one requester: fixed priority to lookup, with a starvation limit that forces an update grant. The granted key is driven to the shared hash, and the result is captured in a single registered output stage with a valid/ready handshake toward the predictor table.

## Interface
- `STARVE_LIMIT`, default 3: consecutive update-blocked grants after which update wins. Legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `lookup_valid` in 1: lookup request present.
- `lookup_key` in 16: key to hash for lookup.
- `lookup_ready` out 1: lookup accepted this cycle.
- `update_valid` in 1: update request present.
- `update_key` in 16: key to hash for update.
- `update_ready` out 1: update accepted this cycle.
- `hash_in` out 16: drives the `in` port of the shared `HashFunction`.
- `hash_out` in 16: `out` port of the shared `HashFunction`, combinational from `hash_in`.
- `out_valid` out 1: output register holds a result.
- `out_hash` out 16: registered hash result.
- `out_src` out 1: origin of the result, 0 = lookup, 1 = update.
- `out_ready` in 1: consumer takes the result when `out_valid` and `out_ready` are both high.

## Operation
- State: output register (`out_valid`, `out_hash`, `out_src`) and a starvation counter `starve` (4 bits, saturating at `STARVE_LIMIT`).
- `can_accept = !out_valid || out_ready`.
- Grant logic (combinational), evaluated only when `can_accept`:
  - Update wins if `update_valid` and (`!lookup_valid` or `starve == STARVE_LIMIT`).
  - Otherwise lookup wins if `lookup_valid`.
  - Otherwise there is no grant.
- If `!can_accept`, there is no grant, and both readies are 0.
- `lookup_ready` / `update_ready` are high only for the granted side. They may depend combinationally on the valids and `out_ready`.
- `hash_in` is the granted key. With no grant, `hash_in` = 16'h0000.
- On a grant, the output register loads `hash_out`, `out_src` = granted side, and `out_valid` = 1.
- With no grant:
  - If `out_valid && out_ready`, then `out_valid` ← 0.
  - Otherwise the register holds.
- Starvation counter:
  - Update granted: `starve` ← 0.
  - Lookup granted while `update_valid` is high: `starve` ← min(`starve`+1, `STARVE_LIMIT`).
  - All other cycles, including stalls (`!can_accept`): `starve` holds.
  - `update_valid` dropping does not clear `starve`.
- Requesters must hold valid and key stable until ready. The block does not check this.
- Reset values: `out_valid` = 0, `out_hash` = 16'h0000, `out_src` = 0, `starve` = 0.
- Outputs during reset:
  - `lookup_ready` and `update_ready` read as 0 in any cycle where `reset` is high.
  - `hash_in` = 0 while `reset` is high.
- Reset mid-transfer discards the held result with no handshake.

## Timing
- Latency: a request accepted in cycle N has its result visible on `out_*` in cycle N+1.
- Throughput: one result per cycle when `out_ready` is held high. Back-to-back grants are allowed, since the register drains and refills in the same cycle.
- Full with `out_ready` = 0: no grants and the register holds. It resumes in the cycle `out_ready` rises, because the drain and the new grant occur together.
- Simultaneous valids:
  - Lookup is granted up to `STARVE_LIMIT` times.
  - The next eligible cycle grants update, and `starve` returns to 0.
- Critical path: `out_ready` → grant → `hash_in` → `HashFunction` → output register D.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` for 2 cycles with both valids high.
  - Required: `out_valid` = 0, both readies = 0, `hash_in` = 0.
  - Required in the first cycle after release: a lookup grant.
- **Single lookup:**
  - Stimulus: `lookup_key` = 16'h0001, `out_ready` = 1.
  - Required: `lookup_ready` = 1 in cycle N.
  - Required in cycle N+1: `out_valid` = 1, `out_hash` = 16'hAAAA, `out_src` = 0.
- **Single update:**
  - Stimulus: `update_key` = 16'h0003.
  - Required in cycle N+1: `out_hash` = 16'hFFFF, `out_src` = 1.
- **Starvation (`STARVE_LIMIT` = 3):**
  - Stimulus: both valids held high, `out_ready` = 1.
  - Required grant sequence: lookup, lookup, lookup, update, lookup, lookup, lookup, update.
- **Back-pressure:**
  - Stimulus: lookup key 16'h0002 is accepted, then `out_ready` = 0 for 4 cycles while update is pending.
  - Required: `out_hash` is held at 16'h5555, `update_ready` = 0, and `starve` is unchanged.
  - Required when `out_ready` rises: update is granted in the same cycle.
- **Drain without refill:**
  - Stimulus: one result is present, `out_ready` = 1, no valids.
  - Required: `out_valid` falls next cycle, and `hash_in` = 0 throughout.

Source files
------------

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one combinational hash between predictor lookup
// and update paths, with a starvation-limited fixed priority to lookup.
module hash_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [15:0] lookup_key,
  output logic        lookup_ready,
  input  logic        update_valid,
  input  logic [15:0] update_key,
  output logic        update_ready,
  output logic [15:0] hash_in,
  input  logic [15:0] hash_out,
  output logic        out_valid,
  output logic [15:0] out_hash,
  output logic        out_src,
  input  logic        out_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve;
  logic       can_accept;
  logic       grant_upd;
  logic       grant_lkp;
  logic       starved;

  // Grant decision; reset masks both grants so readies read 0.
  always_comb begin
    can_accept = !out_valid || out_ready;
    starved    = (starve == LIMIT);
    grant_upd  = !reset && can_accept && update_valid &&
                 (!lookup_valid || starved);
    grant_lkp  = !reset && can_accept && lookup_valid &&
                 !grant_upd;
  end

  assign lookup_ready = grant_lkp;
  assign update_ready = grant_upd;

  // Steer the granted key into the shared hash; idle drives zero.
  always_comb begin
    hash_in = 16'h0000;
    unique case (1'b1)
      grant_upd: hash_in = update_key;
      grant_lkp: hash_in = lookup_key;
      default:   hash_in = 16'h0000;
    endcase
  end

  // Output register: refill on grant, otherwise drain on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hash  <= 16'h0000;
      out_src   <= 1'b0;
    end else if (grant_upd || grant_lkp) begin
      out_valid <= 1'b1;
      out_hash  <= hash_out;
      out_src   <= grant_upd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count lookups that overtook a waiting update, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= 4'd0;
    end else if (grant_upd) begin
      starve <= 4'd0;
    end else if (grant_lkp && update_valid && !starved) begin
      starve <= starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_hash_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [15:0] lookup_key;
  logic        lookup_ready;
  logic        update_valid;
  logic [15:0] update_key;
  logic        update_ready;
  logic [15:0] hash_in;
  logic [15:0] hash_out;
  logic        out_valid;
  logic [15:0] out_hash;
  logic        out_src;
  logic        out_ready;

  int checks = 0;
  int failures = 0;

  hash_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_key   (lookup_key),
    .lookup_ready (lookup_ready),
    .update_valid (update_valid),
    .update_key   (update_key),
    .update_ready (update_ready),
    .hash_in      (hash_in),
    .hash_out     (hash_out),
    .out_valid    (out_valid),
    .out_hash     (out_hash),
    .out_src      (out_src),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // XOR-linear 16-bit hash: h(1)=AAAA, h(2)=5555, h(3)=FFFF.
  function automatic logic [15:0] hf(logic [15:0] k);
    logic pe;
    logic po;
    pe = ^(k & 16'h5555);
    po = ^(k & 16'hAAAA);
    return ({16{pe}} & 16'hAAAA) ^ ({16{po}} & 16'h5555) ^
           (k & 16'hFFFC);
  endfunction

  assign hash_out = hf(hash_in);

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  // Model: 0 = no grant, 1 = lookup, 2 = update.
  function automatic int egrant(logic rst, logic lv, logic uv,
                                logic ordy, logic mv, int ms);
    if (rst) return 0;
    if (mv && !ordy) return 0;
    if (uv && (!lv || ms >= LIMIT)) return 2;
    if (lv) return 1;
    return 0;
  endfunction

  logic        m_valid = 1'b0;
  logic [15:0] m_hash = 16'h0;
  logic        m_src = 1'b0;
  int          m_starve = 0;
  logic        started = 1'b0;
  int          cur_g;

  always_comb
    cur_g = egrant(reset, lookup_valid, update_valid,
                   out_ready, m_valid, m_starve);

  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_hash   <= 16'h0;
      m_src    <= 1'b0;
      m_starve <= 0;
      started  <= 1'b1;
    end else if (cur_g != 0) begin
      m_valid <= 1'b1;
      m_hash  <= hf(cur_g == 1 ? lookup_key : update_key);
      m_src   <= (cur_g == 2);
      if (cur_g == 2)
        m_starve <= 0;
      else if (update_valid)
        m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_lready", lookup_ready, cur_g == 1);
      chk("m_uready", update_ready, cur_g == 2);
      chk("m_hash_in", hash_in,
          cur_g == 1 ? lookup_key :
          cur_g == 2 ? update_key : 16'h0);
      chk("m_ovalid", out_valid, m_valid);
      if (m_valid) begin
        chk("m_ohash", out_hash, m_hash);
        chk("m_osrc", out_src, m_src);
      end
    end
  end

  function automatic int dut_g();
    return lookup_ready ? 1 : (update_ready ? 2 : 0);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int seq [8] = '{1, 1, 1, 2, 1, 1, 1, 2};
  logic lr_s;
  logic ur_s;

  initial begin
    reset = 1'b1;
    lookup_valid = 1'b1;
    lookup_key = 16'h0001;
    update_valid = 1'b1;
    update_key = 16'h0003;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_lready", lookup_ready, 0);
      chk("rst_uready", update_ready, 0);
      chk("rst_hash_in", hash_in, 0);
    end
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("starve_seq", dut_g(), seq[i]);
      if (i > 0)
        chk("seq_hash", out_hash,
            seq[i-1] == 1 ? 16'hAAAA : 16'hFFFF);
      nxt();
    end
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    nxt();
    lookup_valid = 1'b1;
    lookup_key = 16'h0001;
    @(negedge clk);
    chk("lkp_ready", lookup_ready, 1);
    nxt();
    lookup_valid = 1'b0;
    @(negedge clk);
    chk("lkp_ovalid", out_valid, 1);
    chk("lkp_ohash", out_hash, 16'hAAAA);
    chk("lkp_osrc", out_src, 0);
    nxt();
    update_valid = 1'b1;
    update_key = 16'h0003;
    @(negedge clk);
    chk("upd_ready", update_ready, 1);
    nxt();
    update_valid = 1'b0;
    @(negedge clk);
    chk("upd_ohash", out_hash, 16'hFFFF);
    chk("upd_osrc", out_src, 1);
    chk("drain_hin0", hash_in, 0);
    nxt();
    @(negedge clk);
    chk("drain_ovalid", out_valid, 0);
    chk("drain_hin1", hash_in, 0);
    nxt();
    lookup_valid = 1'b1;
    lookup_key = 16'h0002;
    update_valid = 1'b1;
    update_key = 16'h0003;
    @(negedge clk);
    chk("bp_lready", lookup_ready, 1);
    nxt();
    lookup_valid = 1'b0;
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ohash", out_hash, 16'h5555);
      chk("bp_uready", update_ready, 0);
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", update_ready, 1);
    nxt();
    lookup_valid = 1'b1;
    lookup_key = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("prime_lkp", lookup_ready, 1);
      nxt();
    end
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_grant", dut_g(), 0);
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_keep1", dut_g(), 1);
    nxt();
    @(negedge clk);
    chk("stall_keep2", dut_g(), 2);
    nxt();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lr_s = lookup_ready;
      ur_s = update_ready;
      nxt();
      reset = ($urandom_range(0, 199) == 0);
      if (!lookup_valid || lr_s) begin
        lookup_valid = ($urandom_range(0, 2) != 0);
        lookup_key = 16'($urandom);
      end
      if (!update_valid || ur_s) begin
        update_valid = ($urandom_range(0, 2) != 0);
        update_key = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    reset = 1'b0;
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
